// File: rtl/uart_tx.sv
// UART transmitter: takes a word over valid/ready and sends it LSB-first as
// start bit, DATA_BITS data bits, optional parity bit and 1 or 2 stop bits,
// holding each bit for CLKS_PER_BIT clocks on an idle-high line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 414,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,   // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 out,
  output logic                 done
);

  // Reject configurations the frame logic cannot represent.
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           USE_PAR   = (PARITY != 0);
  localparam logic           ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   out_q, out_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  // The current bit has been on the line for CLKS_PER_BIT clocks.
  assign bit_end = (cnt_q == CNT_LAST);

  // State register: all sequential state, synchronous reset has priority.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      // NOTE: the shift register is cleared too so nothing stale from an
      // aborted frame can leak into the next one.
      shift_q  <= '0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      out_q    <= out_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: frame sequencing, baud/bit counting, word capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    unique case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          state_d  = S_START;
          idx_d    = '0;
          shift_d  = data;
          parity_d = (^data) ^ ODD_PAR;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            state_d = USE_PAR ? S_PAR : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: registered line level, ready and done derived from the
  // state being entered so they change on the same edge as the state.
  always_comb begin
    out_d   = 1'b1;
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);
    unique case (state_d)
      S_START: out_d = 1'b0;
      S_DATA:  out_d = shift_d[0];
      S_PAR:   out_d = parity_d;
      default: out_d = 1'b1;
    endcase
  end

  assign out   = out_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: four configurations share one clock and
// reset; expected frames are hand-computed bit vectors (bit 0 = start bit).
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Default configuration: 414 clocks/bit, 8N1.
  logic [7:0] data_def;
  logic       valid_def, ready_def, out_def, done_def;
  // 4 clocks/bit, 8 data bits, odd parity.
  logic [7:0] data_odd;
  logic       valid_odd, ready_odd, out_odd, done_odd;
  // 4 clocks/bit, 8 data bits, even parity.
  logic [7:0] data_even;
  logic       valid_even, ready_even, out_even, done_even;
  // 1 clock/bit, 5 data bits, 2 stop bits.
  logic [4:0] data_fast;
  logic       valid_fast, ready_fast, out_fast, done_fast;

  uart_tx #(.CLKS_PER_BIT(414), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_def (
    .CLKIN(clk), .RESET(rst), .data(data_def), .valid(valid_def),
    .ready(ready_def), .out(out_def), .done(done_def));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .CLKIN(clk), .RESET(rst), .data(data_odd), .valid(valid_odd),
    .ready(ready_odd), .out(out_odd), .done(done_odd));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .CLKIN(clk), .RESET(rst), .data(data_even), .valid(valid_even),
    .ready(ready_even), .out(out_even), .done(done_even));

  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_fast (
    .CLKIN(clk), .RESET(rst), .data(data_fast), .valid(valid_fast),
    .ready(ready_fast), .out(out_fast), .done(done_fast));

  // Selects which instance the frame checker observes.
  logic [1:0] sel;
  logic       out_s, ready_s, done_s;

  always_comb begin
    out_s   = out_def;
    ready_s = ready_def;
    done_s  = done_def;
    case (sel)
      2'd1: begin out_s = out_odd;  ready_s = ready_odd;  done_s = done_odd;  end
      2'd2: begin out_s = out_even; ready_s = ready_even; done_s = done_even; end
      2'd3: begin out_s = out_fast; ready_s = ready_fast; done_s = done_fast; end
      default: ;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered just after the accept edge k. Walks the whole frame checking the
  // line every clock, then stops just after edge k + n*c for the end checks.
  task automatic check_frame(input string tag, input int c, input int n,
                             input logic [15:0] bits);
    int bad_line = 0;
    int bad_hs   = 0;
    for (int t = 0; t < n * c; t++) begin
      if (out_s !== bits[t / c]) bad_line++;
      if (ready_s !== 1'b0 || done_s !== 1'b0) bad_hs++;
      tick(1);
    end
    check({tag, "_line_errors"}, bad_line, 0);
    check({tag, "_busy_handshake_errors"}, bad_hs, 0);
    check({tag, "_end_done"}, done_s, 1);
    check({tag, "_end_ready"}, ready_s, 1);
    check({tag, "_end_out"}, out_s, 1);
  endtask

  initial begin
    int idle_bad;

    sel        = 2'd0;
    rst        = 1'b1;
    data_def   = 8'h00; valid_def  = 1'b0;
    data_odd   = 8'h00; valid_odd  = 1'b0;
    data_even  = 8'h00; valid_even = 1'b0;
    data_fast  = 5'h00; valid_fast = 1'b0;

    // Reset state.
    tick(2);
    check("rst_out", out_def, 1);
    check("rst_ready", ready_def, 0);
    check("rst_done", done_def, 0);
    rst = 1'b0;
    tick(1);
    check("post_rst_ready", ready_def, 1);

    // valid low for 100 clocks: line idle, ready high, no done.
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (out_def !== 1'b1 || ready_def !== 1'b1 || done_def !== 1'b0) idle_bad++;
    end
    check("idle_100_errors", idle_bad, 0);

    // Default 8N1, data 0x55: frame {1, 01010101, 0} = 10'h2AA.
    data_def  = 8'h55;
    valid_def = 1'b1;
    tick(1);
    valid_def = 1'b0;
    data_def  = 8'h00;
    check_frame("def_55", 414, 10, 16'h02AA);
    tick(1);
    check("def_55_done_one_cycle", done_def, 0);

    // Back-to-back with valid held: 0xA3 -> 10'h346, then 0x3C -> 10'h278.
    data_def  = 8'hA3;
    valid_def = 1'b1;
    tick(1);
    data_def  = 8'h3C;                   // changed mid-frame, must not disturb it
    check_frame("b2b_a3", 414, 10, 16'h0346);
    tick(1);                             // single idle clock, then second accept
    data_def  = 8'hFF;
    valid_def = 1'b0;
    check_frame("b2b_3c", 414, 10, 16'h0278);
    tick(1);
    check("b2b_done_one_cycle", done_def, 0);

    // Reset in the middle of data bit 3 of 0xA3 (bit 3 = 0 on the line).
    data_def  = 8'hA3;
    valid_def = 1'b1;
    tick(1);                             // accept edge k
    valid_def = 1'b0;
    tick(4 * 414 + 206);                 // after edge k + 4*414 + 206
    check("mid_bit3_out", out_def, 0);
    rst = 1'b1;
    tick(1);
    check("abort_out", out_def, 1);
    check("abort_ready", ready_def, 0);
    check("abort_done", done_def, 0);
    rst = 1'b0;
    tick(1);
    check("abort_ready_back", ready_def, 1);
    data_def  = 8'h3C;
    valid_def = 1'b1;
    tick(1);
    valid_def = 1'b0;
    check_frame("after_abort_3c", 414, 10, 16'h0278);

    // Odd parity, 0x07: parity 0, frame {1, 0, 00000111, 0} = 11'h40E.
    sel = 2'd1;
    tick(1);
    check("odd_ready", ready_s, 1);
    data_odd  = 8'h07;
    valid_odd = 1'b1;
    tick(1);
    valid_odd = 1'b0;
    check_frame("odd_07", 4, 11, 16'h040E);

    // Even parity, 0x07: parity 1, frame {1, 1, 00000111, 0} = 11'h60E.
    sel = 2'd2;
    tick(1);
    check("even_ready", ready_s, 1);
    data_even  = 8'h07;
    valid_even = 1'b1;
    tick(1);
    valid_even = 1'b0;
    check_frame("even_07", 4, 11, 16'h060E);

    // 1 clock/bit, 5 data, 2 stop, 0x1F: 0,1,1,1,1,1,1,1 = 8'hFE, done at k+8.
    sel = 2'd3;
    tick(1);
    check("fast_ready", ready_s, 1);
    data_fast  = 5'h1F;
    valid_fast = 1'b1;
    tick(1);
    valid_fast = 1'b0;
    check_frame("fast_1f", 1, 8, 16'h00FE);
    tick(1);
    check("fast_done_one_cycle", done_s, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
